// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Sequencing FSM for a multicycle RV32I datapath. Each cycle it
//            drives the ALU operation, every datapath mux select and every
//            register/memory write enable, and it takes the ALU Zero flag
//            for beq. Memory accesses stall on a single-signal ready.
// Ports    : clk, reset_n (synchronous, active low)
//            op, funct3, funct7b5  - fields of the instruction register
//            Zero, mem_ready       - datapath / memory status
//            ALU_control, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
//            IRWrite, PCWrite, MemWrite, RegWrite - datapath commands
//            illegal_op (sticky), state_dbg (current state code)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter bit ENABLE_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [2:0] ALU_control,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_next;
    logic [3:0] w_dec_state;
    logic       w_ready;
    logic [1:0] w_alu_op;
    logic       w_branch;
    logic       w_pc_update;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_op_bad;
    logic       w_funct_bad;

    // With the handshake disabled, memory is assumed to answer every cycle.
    assign w_ready = ENABLE_HANDSHAKE ? mem_ready : 1'b1;

    // While reset is held the outputs present the FETCH decode, whatever
    // state the register still holds from before reset was asserted.
    assign w_dec_state = reset_n ? r_state : S_FETCH;

    // Moore decode of the state into datapath commands.
    always_comb begin
        w_alu_op    = ALUOP_ADD;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        AdrSrc      = 1'b0;
        w_branch    = 1'b0;
        w_pc_update = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_ir_write  = w_ready;
                w_pc_update = w_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays asserted for the whole stalled access.
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU operation decode; unsupported funct3 falls back to ADD and flags.
    always_comb begin
        ALU_control = 3'b000;
        w_funct_bad = 1'b0;
        case (w_alu_op)
            ALUOP_SUB: ALU_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALU_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALU_control = 3'b101;
                    3'b110:  ALU_control = 3'b011;
                    3'b111:  ALU_control = 3'b010;
                    default: w_funct_bad = 1'b1;
                endcase
            end
            default: ALU_control = 3'b000;
        endcase
    end

    // Immediate format follows the opcode, independent of state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next   = S_FETCH;
        w_op_bad = 1'b0;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next   = S_FETCH;
                        w_op_bad = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_op_bad || w_funct_bad) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Write enables are suppressed for the whole time reset is held.
    assign IRWrite    = reset_n & w_ir_write;
    assign PCWrite    = reset_n & ((w_branch & Zero) | w_pc_update);
    assign MemWrite   = reset_n & w_mem_write;
    assign RegWrite   = reset_n & w_reg_write;
    assign illegal_op = r_illegal;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire
